// File: rtl/sccpu_dbg_pkg.sv
// Shared encodings for the SCCOMP run/halt/step debug controller:
// command opcodes, stop-cause codes and sequencer state.
package sccpu_dbg_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;

  localparam logic [1:0] CAUSE_CMD   = 2'd0;
  localparam logic [1:0] CAUSE_BREAK = 2'd1;
  localparam logic [1:0] CAUSE_TMO   = 2'd2;
  localparam logic [1:0] CAUSE_OOB   = 2'd3;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_FAULT = 2'd3
  } run_state_e;

endpackage

// File: rtl/sccpu_stop_detect.sv
// Combinational stop detection: PC out of imem, cycle budget, breakpoint.
// Ports: pc/cycle_cnt/bp regs in; oob, tmo, brk, stop, cause out.
import sccpu_dbg_pkg::*;

module sccpu_stop_detect #(
  parameter int unsigned MAX_CYCLES = 1000,
  parameter logic [31:0] PC_BASE    = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic [31:0] pc,
  input  logic [31:0] cycle_cnt,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic        skip_bp,
  output logic        oob,
  output logic        tmo,
  output logic        brk,
  output logic        stop,
  output logic [1:0]  cause
);

  localparam logic [32:0] SPAN = 33'(IMEM_WORDS) << 2;
  localparam logic [31:0] MAXC = 32'(MAX_CYCLES);

  logic [32:0] off;

  // A PC below the base wraps to a huge 33-bit offset and fails the span test.
  assign off = {1'b0, pc} - {1'b0, PC_BASE};

  assign oob  = (pc[1:0] != 2'b00) | (off >= SPAN);
  assign tmo  = (MAXC != 32'd0) & (cycle_cnt == MAXC);
  assign brk  = bp_en & (pc == bp_addr) & ~skip_bp;
  assign stop = oob | tmo | brk;

  always_comb begin
    cause = CAUSE_CMD;
    unique case (1'b1)
      oob:     cause = CAUSE_OOB;
      tmo:     cause = CAUSE_TMO;
      brk:     cause = CAUSE_BREAK;
      default: cause = CAUSE_CMD;
    endcase
  end

endmodule

// File: rtl/sccpu_run_ctrl.sv
// Run/halt/single-step sequencer gating the SCCOMP CPU clock enable.
// Ports: clk, rstn, pc, cmd_* in; cpu_en, halted, fault, stop_cause, cycle_cnt out.
import sccpu_dbg_pkg::*;

module sccpu_run_ctrl #(
  parameter int unsigned MAX_CYCLES = 1000,
  parameter logic [31:0] PC_BASE    = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter bit          AUTO_RUN   = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        cmd_err,
  output logic        cpu_en,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  stop_cause,
  output logic [31:0] cycle_cnt
);

  localparam run_state_e RST_ST = AUTO_RUN ? ST_RUN : ST_HALT;

  run_state_e  state;
  logic [31:0] step_cnt;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        skip_bp;

  logic        oob;
  logic        tmo;
  logic        brk;
  logic        stop;
  logic [1:0]  det_cause;
  logic        legal;
  logic        cmd_ok;
  logic        active;
  logic        halt_cmd;
  logic        at_bp;

  sccpu_stop_detect #(
    .MAX_CYCLES (MAX_CYCLES),
    .PC_BASE    (PC_BASE),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_det (
    .pc        (pc),
    .cycle_cnt (cycle_cnt),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .skip_bp   (skip_bp),
    .oob       (oob),
    .tmo       (tmo),
    .brk       (brk),
    .stop      (stop),
    .cause     (det_cause)
  );

  always_comb begin
    legal = 1'b0;
    case (cmd_op)
      OP_NOP:    legal = 1'b1;
      OP_RUN:    legal = (state == ST_HALT);
      OP_STEP:   legal = (state == ST_HALT);
      OP_HALT:   legal = active;
      OP_SET_BP: legal = (state != ST_FAULT);
      OP_CLR_BP: legal = (state != ST_FAULT);
      OP_CLEAR:  legal = (state == ST_HALT)
                       | (state == ST_FAULT);
      default:   legal = 1'b0;
    endcase
  end

  assign active    = (state == ST_RUN) | (state == ST_STEP);
  assign cmd_ok    = cmd_valid & legal;
  assign halt_cmd  = cmd_valid & (cmd_op == OP_HALT);
  assign at_bp     = (pc == bp_addr);

  // Stops act in the same cycle: the instruction at pc is not executed.
  assign cpu_en    = active & ~stop & ~halt_cmd;
  assign cmd_ready = 1'b1;
  assign halted    = (state == ST_HALT) | (state == ST_FAULT);
  assign fault     = (state == ST_FAULT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RST_ST;
      step_cnt   <= '0;
      bp_en      <= 1'b0;
      bp_addr    <= '0;
      skip_bp    <= 1'b0;
      cycle_cnt  <= '0;
      stop_cause <= CAUSE_CMD;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= cmd_valid & ~legal;

      if (cpu_en) begin
        skip_bp <= 1'b0;
        if (cycle_cnt != '1)
          cycle_cnt <= cycle_cnt + 32'd1;
      end

      if (cmd_ok && cmd_op == OP_SET_BP) begin
        bp_en   <= 1'b1;
        bp_addr <= cmd_data;
      end
      if (cmd_ok && cmd_op == OP_CLR_BP)
        bp_en <= 1'b0;

      case (state)
        ST_HALT: begin
          if (cmd_ok) begin
            case (cmd_op)
              OP_RUN: begin
                state   <= ST_RUN;
                skip_bp <= at_bp;
              end
              OP_STEP: begin
                state    <= ST_STEP;
                skip_bp  <= at_bp;
                step_cnt <= (cmd_data == 32'd0)
                          ? 32'd1 : cmd_data;
              end
              OP_CLEAR: cycle_cnt <= '0;
              default: ;
            endcase
          end
        end
        ST_RUN, ST_STEP: begin
          if (stop) begin
            state      <= (oob | tmo) ? ST_FAULT : ST_HALT;
            stop_cause <= det_cause;
            step_cnt   <= '0;
          end else if (halt_cmd) begin
            state      <= ST_HALT;
            stop_cause <= CAUSE_CMD;
            step_cnt   <= '0;
          end else if (state == ST_STEP) begin
            step_cnt <= step_cnt - 32'd1;
            if (step_cnt == 32'd1) begin
              state      <= ST_HALT;
              stop_cause <= CAUSE_CMD;
            end
          end
        end
        ST_FAULT: begin
          if (cmd_ok && cmd_op == OP_CLEAR) begin
            state     <= ST_HALT;
            cycle_cnt <= '0;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_sccpu_run_ctrl.sv
// Directed self-checking bench for sccpu_run_ctrl with a tiny PC model
// that advances by one word on every edge where cpu_en is high.
import sccpu_dbg_pkg::*;

module tb_sccpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        cmd_err;
  logic        cpu_en;
  logic        halted;
  logic        fault;
  logic [1:0]  stop_cause;
  logic [31:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_en;
  bit loop_pc = 1'b0;

  sccpu_run_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc         (pc),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .cmd_err    (cmd_err),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .fault      (fault),
    .stop_cause (stop_cause),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: the model CPU advances pc if cpu_en was high at the edge.
  task automatic tick();
    logic en;
    en = cpu_en;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 32'h0;
    if (en)
      pc = (loop_pc && pc >= 32'h1C) ? 32'h0 : pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [2:0] op,
                         input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op,
                        input logic [31:0] d);
    set_cmd(op, d);
    tick();
  endtask

  task automatic count_until_halt();
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted) break;
      if (cpu_en) n_en++;
      tick();
    end
  endtask

  initial begin
    rstn      = 1'b0;
    pc        = 32'h0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 32'h0;
    repeat (2) @(negedge clk);

    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_halted", 32'(halted), 1);
    check("rst_fault", 32'(fault), 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_cause", 32'(stop_cause), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    rstn = 1'b1;
    @(negedge clk);

    // Breakpoint at 0x10: four instructions run, then stop before 0x10.
    do_cmd(OP_SET_BP, 32'h10);
    check("bp_set_err", 32'(cmd_err), 0);
    set_cmd(OP_RUN, 0);
    check("run_cmd_cyc_en", 32'(cpu_en), 0);
    tick();
    check("run_next_en", 32'(cpu_en), 1);
    repeat (4) tick();
    check("brk_pc", pc, 32'h10);
    check("brk_en", 32'(cpu_en), 0);
    check("brk_cycle", cycle_cnt, 4);
    tick();
    check("brk_halted", 32'(halted), 1);
    check("brk_cause", 32'(stop_cause), 1);

    // Resume executes the instruction at the breakpoint once.
    do_cmd(OP_RUN, 0);
    check("resume_en", 32'(cpu_en), 1);
    tick();
    check("resume_pc", pc, 32'h14);
    check("resume_cycle", cycle_cnt, 5);
    check("resume_en2", 32'(cpu_en), 1);
    set_cmd(OP_HALT, 0);
    check("halt_same_cyc", 32'(cpu_en), 0);
    tick();
    check("halt_halted", 32'(halted), 1);
    check("halt_cause", 32'(stop_cause), 0);
    check("halt_cycle", cycle_cnt, 5);

    // STEP 3 then STEP 0 (treated as 1).
    do_cmd(OP_STEP, 3);
    count_until_halt();
    check("step3_n", n_en, 3);
    check("step3_halted", 32'(halted), 1);
    check("step3_cause", 32'(stop_cause), 0);
    check("step3_cycle", cycle_cnt, 8);
    do_cmd(OP_STEP, 0);
    count_until_halt();
    check("step0_n", n_en, 1);
    check("step0_pc", pc, 32'h24);

    // Last step would land on a breakpoint: the break wins.
    do_cmd(OP_SET_BP, 32'h28);
    do_cmd(OP_STEP, 2);
    count_until_halt();
    check("stepbrk_n", n_en, 1);
    check("stepbrk_cause", 32'(stop_cause), 1);
    check("stepbrk_cycle", cycle_cnt, 10);
    do_cmd(OP_CLR_BP, 0);

    // Illegal HALT while halted: single-cycle error pulse.
    do_cmd(OP_HALT, 0);
    check("err_pulse", 32'(cmd_err), 1);
    tick();
    check("err_clear", 32'(cmd_err), 0);
    do_cmd(OP_CLEAR, 0);
    check("clr_cycle", cycle_cnt, 0);
    check("clr_cause_kept", 32'(stop_cause), 1);

    // Cycle budget exhaustion in a tight loop.
    loop_pc = 1'b1;
    do_cmd(OP_RUN, 0);
    for (int i = 0; i < 1100; i++) begin
      if (fault) break;
      tick();
    end
    check("tmo_fault", 32'(fault), 1);
    check("tmo_cause", 32'(stop_cause), 2);
    check("tmo_cycle", cycle_cnt, 1000);
    check("tmo_halted", 32'(halted), 1);
    do_cmd(OP_RUN, 0);
    check("fault_run_err", 32'(cmd_err), 1);
    check("fault_stays", 32'(fault), 1);
    do_cmd(OP_CLEAR, 0);
    check("fclr_fault", 32'(fault), 0);
    check("fclr_halted", 32'(halted), 1);
    check("fclr_cycle", cycle_cnt, 0);
    check("fclr_cause", 32'(stop_cause), 2);
    loop_pc = 1'b0;

    // Last imem word executes, the next PC faults.
    pc = 32'h1FC;
    do_cmd(OP_RUN, 0);
    check("last_word_en", 32'(cpu_en), 1);
    tick();
    check("oob_end_en", 32'(cpu_en), 0);
    check("oob_end_cycle", cycle_cnt, 1);
    tick();
    check("oob_end_fault", 32'(fault), 1);
    check("oob_end_cause", 32'(stop_cause), 3);
    do_cmd(OP_CLEAR, 0);

    pc = 32'h6;
    do_cmd(OP_RUN, 0);
    check("oob_mis_en", 32'(cpu_en), 0);
    tick();
    check("oob_mis_fault", 32'(fault), 1);
    check("oob_mis_cause", 32'(stop_cause), 3);
    do_cmd(OP_CLEAR, 0);

    // Asynchronous reset in the middle of a step burst.
    pc = 32'h0;
    do_cmd(OP_SET_BP, 32'h40);
    do_cmd(OP_STEP, 8);
    repeat (3) tick();
    check("mid_cycle", cycle_cnt, 3);
    check("mid_en", 32'(cpu_en), 1);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_en", 32'(cpu_en), 0);
    check("arst_halted", 32'(halted), 1);
    check("arst_cycle", cycle_cnt, 0);
    check("arst_cause", 32'(stop_cause), 0);
    @(negedge clk);
    rstn = 1'b1;
    pc   = 32'h40;
    @(negedge clk);
    do_cmd(OP_RUN, 0);
    check("arst_bp_cleared", 32'(cpu_en), 1);
    do_cmd(OP_HALT, 0);
    check("final_halted", 32'(halted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
